// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one D-bus slave port between NUM_MASTERS requesters.
// Optional WAIT-state watchdog enabled by defining DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_bstart,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_ttype,
  input  logic [NUM_MASTERS*2-1:0]      m_tsize,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_bstart,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_ttype,
  output logic [1:0]                    s_tsize,
  input  logic                          s_done,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    dbg_state_o
);

  // Handshake: a master holds m_bstart until its m_done pulse; the slave sees a
  // one-cycle s_bstart with stable fields and answers with a one-cycle s_done.
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   sb_q, sb_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   ttype_q, ttype_d;
  logic [1:0]             tsize_q, tsize_d;

  logic                   found;
  logic [PW-1:0]          winner;
  logic [PW-1:0]          next_ptr;
  logic                   tmo;
  logic                   fin;

  // First requester at or after ptr, wrapping modulo NUM_MASTERS.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && m_bstart[(int'(ptr_q) + k) % NUM_MASTERS]) begin
        found  = 1'b1;
        winner = PW'((int'(ptr_q) + k) % NUM_MASTERS);
      end
    end
  end

  assign next_ptr = (owner_q == PW'(NUM_MASTERS - 1)) ? '0 : owner_q + PW'(1);

`ifdef DBUS_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign tmo = (state_q == ST_WAIT) && (cnt_q >= 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT && !s_done && !tmo) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // A coincident s_done is a normal completion and takes priority.
  assign m_err   = (tmo && !s_done) ? gnt_q : '0;
  assign m_rdata = (tmo && !s_done) ? DATA_W'(32'hDEAD_BEEF) : s_rdata;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo     = 1'b0;
  assign m_err   = '0;
  assign m_rdata = s_rdata;
`endif

  assign fin    = (state_q == ST_WAIT) && (s_done || tmo);
  assign m_done = fin ? gnt_q : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    sb_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ttype_d = ttype_q;
    tsize_d = tsize_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          owner_d = winner;
          addr_d  = m_addr[winner*ADDR_W +: ADDR_W];
          wdata_d = m_wdata[winner*DATA_W +: DATA_W];
          ttype_d = m_ttype[winner];
          tsize_d = m_tsize[winner*2 +: 2];
          gnt_d   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
          sb_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fin) begin
          state_d = ST_IDLE;
          ptr_d   = next_ptr;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      sb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ttype_q <= 1'b0;
      tsize_q <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      sb_q    <= sb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ttype_q <= ttype_d;
      tsize_q <= tsize_d;
    end
  end

  assign m_gnt       = gnt_q;
  assign s_bstart    = sb_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_ttype     = ttype_q;
  assign s_tsize     = tsize_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: vector table plus hand-written reset and
// watchdog sequences (watchdog part active when DBUS_ARB_TIMEOUT_EN is defined).
module tb_dbus_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [31:0] A0 = 32'h1000_0004;
  localparam logic [31:0] W0 = 32'hCAFE_F00D;
  localparam logic [31:0] A1 = 32'h2000_0010;
  localparam logic [31:0] W1 = 32'h0BAD_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_bstart;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_ttype;
  logic [3:0]  m_tsize;
  logic [1:0]  m_gnt, m_done, m_err;
  logic [31:0] m_rdata;
  logic        s_bstart;
  logic [31:0] s_addr, s_wdata;
  logic        s_ttype;
  logic [1:0]  s_tsize;
  logic        s_done;
  logic [31:0] s_rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  bstart;
    logic        sdone;
    logic [31:0] srdata;
    logic [1:0]  e_gnt;
    logic [1:0]  e_done;
    logic        e_sb;
    int          e_own;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vq[$];

  dbus_arbiter #(
    .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_bstart(m_bstart), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ttype(m_ttype), .m_tsize(m_tsize),
    .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
    .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_done(s_done), .s_rdata(s_rdata),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then let outputs settle.
  task automatic tick(input logic [1:0] bs, input logic sd, input logic [31:0] rd);
    @(negedge clk);
    m_bstart = bs;
    s_done   = sd;
    s_rdata  = rd;
    #1;
  endtask

  task automatic add(input logic [1:0] bs, input logic sd, input logic [31:0] rd,
                     input logic [1:0] g, input logic [1:0] d, input logic sb,
                     input int own, input logic [1:0] st);
    vec_t v;
    v.bstart = bs; v.sdone = sd; v.srdata = rd; v.e_gnt = g; v.e_done = d;
    v.e_sb = sb; v.e_own = own; v.e_state = st;
    vq.push_back(v);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"},    32'(m_gnt),    32'd0);
    chk({tag, "_done"},   32'(m_done),   32'd0);
    chk({tag, "_err"},    32'(m_err),    32'd0);
    chk({tag, "_sb"},     32'(s_bstart), 32'd0);
    chk({tag, "_saddr"},  s_addr,        32'd0);
    chk({tag, "_swdata"}, s_wdata,       32'd0);
    chk({tag, "_sttype"}, 32'(s_ttype),  32'd0);
    chk({tag, "_stsize"}, 32'(s_tsize),  32'd0);
    chk({tag, "_state"},  32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    rst      = 1'b1;
    m_bstart = 2'b00;
    m_addr   = {A1, A0};
    m_wdata  = {W1, W0};
    m_ttype  = 2'b01;            // master0 WRITE, master1 READ
    m_tsize  = {2'd1, 2'd2};     // master0 WORD, master1 HALFWORD
    s_done   = 1'b0;
    s_rdata  = 32'h0;

    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Contention with alternation, read return, spurious done, owner drop, non-owner change.
    add(2'b11, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b11, 0, 32'h0,         2'b01, 2'b00, 1, 0, S_ISSUE);
    add(2'b11, 1, 32'hAAAA_0001, 2'b01, 2'b01, 0, 0, S_WAIT);
    add(2'b11, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b11, 0, 32'h0,         2'b10, 2'b00, 1, 1, S_ISSUE);
    add(2'b11, 1, 32'hAAAA_0002, 2'b10, 2'b10, 0, 0, S_WAIT);
    add(2'b11, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b11, 0, 32'h0,         2'b01, 2'b00, 1, 0, S_ISSUE);
    add(2'b11, 1, 32'hAAAA_0003, 2'b01, 2'b01, 0, 0, S_WAIT);
    add(2'b11, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b11, 0, 32'h0,         2'b10, 2'b00, 1, 1, S_ISSUE);
    add(2'b11, 1, 32'h1234_5678, 2'b10, 2'b10, 0, 0, S_WAIT);
    add(2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b00, 1, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b01, 1, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b10, 1, 32'h0,         2'b01, 2'b00, 1, 0, S_ISSUE);
    add(2'b10, 0, 32'h0,         2'b01, 2'b00, 0, 0, S_WAIT);
    add(2'b10, 1, 32'h5555_AAAA, 2'b01, 2'b01, 0, 0, S_WAIT);
    add(2'b10, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);
    add(2'b00, 0, 32'h0,         2'b10, 2'b00, 1, 1, S_ISSUE);
    add(2'b00, 0, 32'h0,         2'b10, 2'b00, 0, 0, S_WAIT);
    add(2'b00, 1, 32'h0F0F_F0F0, 2'b10, 2'b10, 0, 0, S_WAIT);
    add(2'b00, 0, 32'h0,         2'b00, 2'b00, 0, 0, S_IDLE);

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].bstart, vq[i].sdone, vq[i].srdata);
      chk($sformatf("v%0d_gnt", i),   32'(m_gnt),     32'(vq[i].e_gnt));
      chk($sformatf("v%0d_done", i),  32'(m_done),    32'(vq[i].e_done));
      chk($sformatf("v%0d_err", i),   32'(m_err),     32'd0);
      chk($sformatf("v%0d_sb", i),    32'(s_bstart),  32'(vq[i].e_sb));
      chk($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vq[i].e_state));
      if (vq[i].e_sb) begin
        chk($sformatf("v%0d_saddr", i),  s_addr,       (vq[i].e_own == 0) ? A0 : A1);
        chk($sformatf("v%0d_swdata", i), s_wdata,      (vq[i].e_own == 0) ? W0 : W1);
        chk($sformatf("v%0d_sttype", i), 32'(s_ttype), (vq[i].e_own == 0) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_stsize", i), 32'(s_tsize), (vq[i].e_own == 0) ? 32'd2 : 32'd1);
      end
      if (vq[i].e_done != 2'b00)
        chk($sformatf("v%0d_rdata", i), m_rdata, vq[i].srdata);
    end

    // Single master write with done three cycles after start; ptr is 0 here.
    tick(2'b01, 0, 32'h0);
    tick(2'b01, 0, 32'h0);
    chk("single_gnt", 32'(m_gnt), 32'h1);
    chk("single_sb", 32'(s_bstart), 32'h1);
    chk("single_saddr", s_addr, A0);
    chk("single_swdata", s_wdata, W0);
    tick(2'b01, 0, 32'h0);
    chk("single_fields_held", s_addr, A0);
    chk("single_sb_once", 32'(s_bstart), 32'h0);
    tick(2'b01, 0, 32'h0);
    tick(2'b01, 1, 32'h0);
    chk("single_done", 32'(m_done), 32'h1);
    tick(2'b10, 0, 32'h0);
    chk("single_gnt_clear", 32'(m_gnt), 32'h0);

    // Master1 in flight, reset two cycles into WAIT, then stray done.
    tick(2'b10, 0, 32'h0);
    chk("rstw_gnt", 32'(m_gnt), 32'h2);
    tick(2'b10, 0, 32'h0);
    tick(2'b10, 0, 32'h0);
    tick(2'b10, 0, 32'h0);
    chk("rstw_in_wait", 32'(dbg_state), 32'(S_WAIT));
    rst = 1'b1;
    #1;
    chk_zero_outputs("rst_mid_wait");
    tick(2'b00, 0, 32'h0);
    rst = 1'b0;
    tick(2'b00, 1, 32'h7777_7777);
    chk("stray_done", 32'(m_done), 32'h0);
    tick(2'b11, 0, 32'h0);
    chk("stray_state", 32'(dbg_state), 32'(S_IDLE));
    chk("stray_gnt", 32'(m_gnt), 32'h0);
    tick(2'b11, 0, 32'h0);
    chk("ptr_after_rst", 32'(m_gnt), 32'h1);

`ifdef DBUS_ARB_TIMEOUT_EN
    // Slave never answers master0; watchdog fires 8 cycles into WAIT.
    for (int w = 0; w < 8; w++) begin
      tick(2'b11, 0, 32'h0);
      chk($sformatf("tmo_w%0d_done", w), 32'(m_done), 32'h0);
      chk($sformatf("tmo_w%0d_err", w), 32'(m_err), 32'h0);
    end
    tick(2'b11, 0, 32'h0);
    chk("tmo_err", 32'(m_err), 32'h1);
    chk("tmo_done", 32'(m_done), 32'h1);
    chk("tmo_rdata", m_rdata, 32'hDEAD_BEEF);
    tick(2'b11, 0, 32'h0);
    chk("tmo_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("tmo_err_clear", 32'(m_err), 32'h0);
    tick(2'b11, 0, 32'h0);
    chk("tmo_next_owner", 32'(m_gnt), 32'h2);
`endif

    tick(2'b00, 0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Round-robin arbiter sharing one D-bus slave port between NUM_MASTERS requesters, e.g. rv core0 data port and the debug module's system-bus access.
- Sits between the masters and dbus_interconnect.
- Latches the winning master's request, issues a single-cycle start to the slave side, holds the request stable until the slave completes, then routes completion back to the owner.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m_bstart  in  NUM_MASTERS  per-master request level; held until that master's m_done
- m_addr  in  NUM_MASTERS*ADDR_W  per-master address, packed, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data
- m_ttype  in  NUM_MASTERS  per-master type: 0=READ, 1=WRITE
- m_tsize  in  NUM_MASTERS*2  per-master size: 0=BYTE, 1=HALFWORD, 2=WORD
- m_gnt  out  NUM_MASTERS  one-hot owner indication
- m_done  out  NUM_MASTERS  one-cycle completion pulse to the owner
- m_err  out  NUM_MASTERS  one-cycle error pulse (optional feature only, else 0)
- m_rdata  out  DATA_W  read data, broadcast to all masters
- s_bstart  out  1  one-cycle transaction start to the slave side
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_ttype  out  1  latched type
- s_tsize  out  2  latched size
- s_done  in  1  slave completion pulse
- s_rdata  in  DATA_W  slave read data, valid with s_done

Behaviour:
- Reset (async, rst=1): state=IDLE; ptr=0; all outputs 0 (m_gnt, m_done, m_err, s_bstart, s_addr, s_wdata, s_ttype, s_tsize).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any m_bstart is set, the winner is the first set bit searching ptr, ptr+1, ... modulo NUM_MASTERS.
  - On the clock edge: owner <= winner; s_addr/s_wdata/s_ttype/s_tsize <= winner's fields; m_gnt <= onehot(winner); next state ISSUE.
  - With no request: stay in IDLE, m_gnt=0.
- ISSUE:
  - s_bstart=1 for exactly this cycle (registered); next state WAIT unconditionally.
  - s_done is ignored in ISSUE; the slave must not complete in the same cycle as its start.
- WAIT:
  - s_ addr/data/type/size held stable; m_gnt held.
  - On s_done=1: m_done[owner]=1 combinationally in that cycle; m_rdata=s_rdata.
  - Next state IDLE; ptr <= (owner+1) mod NUM_MASTERS; m_gnt <= 0.
- m_rdata = s_rdata at all times (pass-through). Masters sample it only with their own m_done.
- Latency: request in IDLE -> m_gnt at +1 cycle -> s_bstart at +1 cycle (same cycle as gnt, ISSUE state). Minimum total from request to done is 3 cycles.
- Back-to-back: the cycle after m_done the FSM is in IDLE and re-arbitrates. A master still holding m_bstart after its own m_done is treated as a new request.
- Owner drops m_bstart mid-transaction: ignored; the transaction completes and m_done still pulses.
- Non-owner request changes while the bus is busy: no effect until IDLE.
- Simultaneous requests: resolved by ptr only. Starvation-free; each master waits at most NUM_MASTERS-1 transactions.
- Reset mid-operation: immediate return to IDLE. No m_done pulse. An in-flight slave transaction is abandoned, and a later s_done in IDLE is ignored.
- s_done outside WAIT: ignored, no m_done.

Optional Feature:
- Macro: DBUS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without s_done.
  - When it reaches TIMEOUT_CYCLES: m_err[owner]=1 and m_done[owner]=1 for one cycle; m_rdata forced to 32'hDEAD_BEEF for that cycle; state -> IDLE; ptr advances.
  - s_done in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; WAIT lasts until s_done (may hang); m_err tied to 0.

Test Plan:
- Single master: m_bstart[0]=1, addr=32'h1000_0004, WRITE, WORD, wdata=32'hCAFE_F00D. Required: m_gnt=2'b01 at +1; s_bstart pulse at +1 with those fields; slave s_done 3 cycles later -> m_done[0] that same cycle; m_gnt=0 next cycle.
- Contention: both masters request in the same cycle from reset (ptr=0). Required: master 0 served first, then master 1 immediately after; repeat with both held continuously -> strict alternation 0,1,0,1 over 4 transactions.
- Read return: master 1 READ, slave returns s_rdata=32'h1234_5678 with s_done. Required: m_done[1]=1, m_rdata=32'h1234_5678 that cycle; m_done[0]=0.
- Reset mid-WAIT: assert rst 2 cycles into WAIT. Required: all outputs 0 asynchronously, state IDLE, ptr=0; a following stray s_done produces no m_done.
- Spurious/early done: s_done asserted in IDLE and ISSUE. Required: no m_done, FSM unaffected; the transaction completes only on the s_done in WAIT.
- With DBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds. Required: m_err[owner] and m_done[owner] pulse together 8 cycles after entering WAIT, with m_rdata=32'hDEAD_BEEF; arbiter then serves the other pending master.
